// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned v = value - 1; v != 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Stalled-access watchdog: counts strobe-without-response cycles and flags the last one.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int unsigned timeout = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic clear,
  output logic expired
);

  localparam int unsigned cw = clog2(timeout);
  localparam logic [cw-1:0] last_count = cw'(timeout - 1);

  logic [cw-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst || clear || !active) count <= '0;
    else                          count <= count + cw'(1);
  end

  assign expired = active && (count == last_count);

endmodule

// File: rtl/wb_arb2.sv
// Two-master round-robin Wishbone arbiter with per-cycle grant hold and watchdog abort.
module wb_arb2
  import wb_arb_pkg::*;
#(
  parameter int unsigned adr_width = 32,
  parameter int unsigned dat_width = 32,
  parameter int unsigned timeout   = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [adr_width-1:0]   m0_adr_i,
  input  logic [dat_width-1:0]   m0_dat_i,
  output logic [dat_width-1:0]   m0_dat_o,
  input  logic [dat_width/8-1:0] m0_sel_i,
  input  logic                   m0_we_i,
  input  logic                   m0_cyc_i,
  input  logic                   m0_stb_i,
  output logic                   m0_ack_o,
  output logic                   m0_err_o,
  input  logic [adr_width-1:0]   m1_adr_i,
  input  logic [dat_width-1:0]   m1_dat_i,
  output logic [dat_width-1:0]   m1_dat_o,
  input  logic [dat_width/8-1:0] m1_sel_i,
  input  logic                   m1_we_i,
  input  logic                   m1_cyc_i,
  input  logic                   m1_stb_i,
  output logic                   m1_ack_o,
  output logic                   m1_err_o,
  output logic [adr_width-1:0]   s_adr_o,
  output logic [dat_width-1:0]   s_dat_o,
  input  logic [dat_width-1:0]   s_dat_i,
  output logic [dat_width/8-1:0] s_sel_o,
  output logic                   s_we_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  output logic [1:0]             gnt_o,
  output logic                   timeout_o
);

  state_t state, state_next;
  logic   last;
  logic   wd_active, wd_expired;

  // Round-robin pick: on contention, the master not served last wins.
  function automatic state_t pick(input logic req0, input logic req1, input logic prev);
    if (req0 && req1) return (prev == M0) ? GNT1 : GNT0;
    else if (req0)    return GNT0;
    else if (req1)    return GNT1;
    else              return IDLE;
  endfunction

  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = pick(m0_cyc_i, m1_cyc_i, last);
      GNT0: begin
        if (!m0_cyc_i)       state_next = m1_cyc_i ? GNT1 : IDLE;
        else if (wd_expired) state_next = ABORT;
      end
      GNT1: begin
        if (!m1_cyc_i)       state_next = m0_cyc_i ? GNT0 : IDLE;
        else if (wd_expired) state_next = ABORT;
      end
      ABORT: begin
        if (last == M0 && m0_cyc_i)      state_next = GNT0;
        else if (last == M1 && m1_cyc_i) state_next = GNT1;
        else                             state_next = pick(m0_cyc_i, m1_cyc_i, last);
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      last  <= M1;
    end else begin
      state <= state_next;
      if (state_next == GNT0)      last <= M0;
      else if (state_next == GNT1) last <= M1;
    end
  end

  always_comb begin
    s_adr_o   = '0;
    s_dat_o   = '0;
    s_sel_o   = '0;
    s_we_o    = 1'b0;
    s_cyc_o   = 1'b0;
    s_stb_o   = 1'b0;
    m0_ack_o  = 1'b0;
    m0_err_o  = 1'b0;
    m1_ack_o  = 1'b0;
    m1_err_o  = 1'b0;
    gnt_o     = 2'b00;
    timeout_o = 1'b0;
    case (state)
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i;
        gnt_o    = 2'b01;
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i;
        gnt_o    = 2'b10;
      end
      ABORT: begin
        timeout_o = 1'b1;
        if (last == M0) m0_err_o = 1'b1;
        else            m1_err_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign wd_active = (state == GNT0 || state == GNT1) && s_stb_o && !s_ack_i && !s_err_i;

  wb_arb_watchdog #(.timeout(timeout)) u_wd (
    .clk     (clk),
    .rst     (rst),
    .active  (wd_active),
    .clear   (state_next != state),
    .expired (wd_expired)
  );

endmodule

// File: tb/tb_wb_arb2.sv
// Directed bench for wb_arb2: arbitration, block hold, watchdog abort, reset and error paths.
module tb_wb_arb2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o, m1_adr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m0_sel_i, m1_sel_i, s_sel_o;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
  logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, timeout_o;
  logic [1:0]  gnt_o;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  wb_arb2 #(.adr_width(32), .dat_width(32), .timeout(8)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
    .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
    .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i), .s_sel_o(s_sel_o),
    .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Inputs change 1 ns after the rising edge; checks sample mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
    m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
    s_dat_i = '0; s_ack_i = 0; s_err_i = 0;
    step(); step();
    #3;
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_cyc", s_cyc_o, 0);
    chk("rst_stb", s_stb_o, 0);
    chk("rst_acks", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 4'b0000);
    chk("rst_timeout", timeout_o, 0);
    rst = 1'b1;

    // single master write
    step();
    m0_adr_i = 32'h7002_0000; m0_dat_i = 32'h0000_00A5; m0_sel_i = 4'hF;
    m0_we_i = 1; m0_cyc_i = 1; m0_stb_i = 1;
    #3;
    chk("t1_latency_cyc", s_cyc_o, 0);
    chk("t1_latency_gnt", gnt_o, 2'b00);
    step(); #3;
    chk("t1_cyc", s_cyc_o, 1);
    chk("t1_stb", s_stb_o, 1);
    chk("t1_adr", s_adr_o, 32'h7002_0000);
    chk("t1_dat", s_dat_o, 32'h0000_00A5);
    chk("t1_sel_we", {s_sel_o, s_we_o}, 5'b11111);
    chk("t1_gnt", gnt_o, 2'b01);
    chk("t1_noack_yet", m0_ack_o, 0);
    step(); s_ack_i = 1; #3;
    chk("t1_m0_ack", m0_ack_o, 1);
    chk("t1_m1_ack", m1_ack_o, 0);
    step(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; #3;
    chk("t1_hold_gnt", gnt_o, 2'b01);
    step(); #3;
    chk("t1_idle_gnt", gnt_o, 2'b00);
    chk("t1_idle_cyc", s_cyc_o, 0);

    // simultaneous request after reset, handoff without bubble
    step(); rst = 0;
    step(); rst = 1;
    m0_adr_i = 32'h100; m0_we_i = 0; m0_cyc_i = 1; m0_stb_i = 1;
    m1_adr_i = 32'h200; m1_we_i = 0; m1_cyc_i = 1; m1_stb_i = 1; m1_sel_i = 4'hF;
    step(); #3;
    chk("t2_first_gnt", gnt_o, 2'b01);
    chk("t2_first_adr", s_adr_o, 32'h100);
    step(); s_ack_i = 1; #3;
    chk("t2_m0_ack", m0_ack_o, 1);
    chk("t2_m1_noack", m1_ack_o, 0);
    step(); s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0; #3;
    chk("t2_drop_gnt", gnt_o, 2'b01);
    step(); #3;
    chk("t2_handoff_gnt", gnt_o, 2'b10);
    chk("t2_handoff_adr", s_adr_o, 32'h200);
    step(); m1_cyc_i = 0; m1_stb_i = 0; #3;
    step(); m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1; #3;
    chk("t2_idle_gnt", gnt_o, 2'b00);
    step(); #3;
    chk("t2_rr_gnt", gnt_o, 2'b01);

    // block hold: m1 keeps the grant for four beats while m0 waits
    step(); m0_cyc_i = 0; m0_stb_i = 0; #3;
    step(); m0_cyc_i = 1; m0_stb_i = 1; #3;
    chk("t3_gnt_m1", gnt_o, 2'b10);
    for (int i = 0; i < 4; i++) begin
      step(); s_ack_i = 1; s_dat_i = 32'h11 * (i + 1); #3;
      chk("t3_beat_gnt", gnt_o, 2'b10);
      chk("t3_beat_ack", m1_ack_o, 1);
      chk("t3_beat_dat", m1_dat_o, 32'h11 * (i + 1));
      chk("t3_beat_m0_ack", m0_ack_o, 0);
    end
    step(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; #3;
    chk("t3_release_gnt", gnt_o, 2'b10);
    step(); #3;
    chk("t3_m0_gnt", gnt_o, 2'b01);

    // watchdog: stb at cycle k, abort visible at k+8
    step(); m0_cyc_i = 0; m0_stb_i = 0; #3;
    step(); m0_cyc_i = 1; m0_stb_i = 1; #3;
    step(); #3;
    chk("t4_stb_k", s_stb_o, 1);
    repeat (6) step();
    step(); #3;
    chk("t4_k7_timeout", timeout_o, 0);
    chk("t4_k7_err", m0_err_o, 0);
    chk("t4_k7_cyc", s_cyc_o, 1);
    step(); #3;
    chk("t4_abort_err", m0_err_o, 1);
    chk("t4_abort_timeout", timeout_o, 1);
    chk("t4_abort_cyc_stb", {s_cyc_o, s_stb_o}, 2'b00);
    chk("t4_abort_m1_err", m1_err_o, 0);
    step(); m0_cyc_i = 0; m0_stb_i = 0; #3;
    chk("t4_regrant", gnt_o, 2'b01);
    chk("t4_pulse_end", timeout_o, 0);
    chk("t4_err_end", m0_err_o, 0);
    step(); #3;
    chk("t4_idle", gnt_o, 2'b00);

    // reset during m1's second beat
    step(); m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 0; #3;
    step(); s_ack_i = 1; s_dat_i = 32'h55; #3;
    chk("t5_beat1_gnt", gnt_o, 2'b10);
    chk("t5_beat1_ack", m1_ack_o, 1);
    step(); rst = 0; #3;
    step(); rst = 1; m0_cyc_i = 1; m0_stb_i = 1; #3;
    chk("t5_rst_gnt", gnt_o, 2'b00);
    chk("t5_rst_cyc", s_cyc_o, 0);
    chk("t5_rst_noack", m1_ack_o, 0);
    step(); s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0; #3;
    chk("t5_m0_wins", gnt_o, 2'b01);

    // slave error passthrough clears the watchdog
    step(); #3;
    step(); s_err_i = 1; #3;
    chk("t6_err_pass", m0_err_o, 1);
    chk("t6_err_other", m1_err_o, 0);
    chk("t6_err_noack", m0_ack_o, 0);
    chk("t6_count_before", dut.u_wd.count, 2);
    chk("t6_timeout_low", timeout_o, 0);
    step(); s_err_i = 0; #3;
    chk("t6_count_cleared", dut.u_wd.count, 0);
    chk("t6_timeout_still_low", timeout_o, 0);
    chk("t6_gnt_held", gnt_o, 2'b01);
    step(); m0_cyc_i = 0; m0_stb_i = 0;
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog_time: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/wb_arb2.md
# wb_arb2

Two-master Wishbone arbiter that shares one slave port, such as a wb_uart, wb_gpio or wb_timer instance, between two requesters. Typical requesters are the LM32 data bus (via a conbus slave slot) and a hardware sequencer. Arbitration is round-robin with the grant held for the whole bus cycle. A watchdog terminates a stalled slave access with an error. The block sits between the wb_conbus_top slave port and the peripheral.

## Interface
Parameters:
- adr_width, 32, address width of masters and slave
- dat_width, 32, data width; sel width is dat_width/8
- timeout, 256, stb-without-ack cycles before abort; legal range 2..65535

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- mN_adr_i  in  adr_width  master N address (N = 0, 1)
- mN_dat_i  in  dat_width  master N write data
- mN_dat_o  out  dat_width  master N read data
- mN_sel_i  in  dat_width/8  master N byte select
- mN_we_i  in  1  master N write enable
- mN_cyc_i  in  1  master N cycle
- mN_stb_i  in  1  master N strobe
- mN_ack_o  out  1  master N acknowledge
- mN_err_o  out  1  master N error
- s_adr_o  out  adr_width  slave address
- s_dat_o  out  dat_width  slave write data
- s_dat_i  in  dat_width  slave read data
- s_sel_o  out  dat_width/8  slave byte select
- s_we_o  out  1  slave write enable
- s_cyc_o  out  1  slave cycle
- s_stb_o  out  1  slave strobe
- s_ack_i  in  1  slave acknowledge
- s_err_i  in  1  slave error
- gnt_o  out  2  one-hot current grant; 00 when idle
- timeout_o  out  1  one-cycle pulse on watchdog abort

## Operation
- States: IDLE, GNT0, GNT1, ABORT. A registered `last` bit holds the last master served; `last` resets to 1 so m0 wins first.
- A master requests when mN_cyc_i=1.
- IDLE:
  - One master requests: grant it.
  - Both request: grant the master other than `last`.
  - On entry to GNTn, set `last` to n.
- GNTn:
  - Slave outputs come combinationally from master n: adr, dat, sel, we, cyc, stb.
  - mn_ack_o = s_ack_i and mn_err_o = s_err_i. The non-granted master sees ack=0 and err=0.
  - mN_dat_o = s_dat_i is broadcast to both masters.
  - The grant is held while mn_cyc_i=1, so block transfers are never split.
- Leaving GNTn when mn_cyc_i drops:
  - Other master requesting: go directly to GNT(other), with no idle bubble.
  - Otherwise: go to IDLE.
- Watchdog:
  - Counter increments each cycle in GNTn with s_stb_o=1 and s_ack_i=0 and s_err_i=0.
  - It clears on ack, on err, on stb=0, on a state change, and on reset.
  - When the count reaches timeout-1 with no ack: next state is ABORT.
- ABORT, exactly one cycle:
  - s_cyc_o=0, s_stb_o=0.
  - err_o=1 to the aborted master; timeout_o=1.
  - Then return to GNTn if that master still holds cyc, else apply the IDLE rules.
- IDLE slave outputs: cyc, stb and we = 0; adr, dat and sel = 0.
- Simultaneous s_ack_i and s_err_i: both are passed through; the watchdog clears.

## Timing
- Reset (rst=0 at a clk edge) forces, from the next cycle:
  - state IDLE, gnt_o=00, counter 0, `last`=1, timeout_o=0.
  - all ack_o and err_o = 0, s_cyc_o=0, s_stb_o=0.
- Reset mid-transfer drops s_cyc_o the cycle after the edge and issues no ack.
- Arbitration latency: mN_cyc_i rises in cycle k, so s_cyc_o/s_stb_o rise in cycle k+1.
- Handoff: m0 drops cyc in cycle k while m1 requests, so m1 is on the slave in cycle k+1.
- Ack and err paths are combinational: zero added latency once granted.
- Abort timing: stb is asserted in cycle k with no ack thereafter, so err_o and timeout_o are high in cycle k+timeout.
- Grant and state are registered; no combinational path from mN_cyc_i to gnt_o.

## Structure
- Package wb_arb_pkg holds:
  - state encoding: IDLE=2'd0, GNT0=2'd1, GNT1=2'd2, ABORT=2'd3
  - master index constants
  - the clog2 helper for the watchdog width
- Sub-module wb_arb_watchdog holds the counter, clear/increment logic and terminal-count output; width is clog2(timeout).
- Top level holds the FSM, the round-robin pointer and the output muxes.

## Test plan
- Single master: m0 cyc/stb in cycle 1 with adr=0x70020000, we=1, dat=0x000000A5, slave acks in cycle 3 -> s_cyc_o high from cycle 2, m0_ack_o high in cycle 3, gnt_o=01, m1_ack_o=0 throughout.
- Simultaneous request: both raise cyc in the same cycle after reset -> m0 granted first. On m0 cyc drop, m1 granted the next cycle with no IDLE cycle. Repeat with both requesting again -> m0 granted (round-robin).
- Block hold: m1 performs 4 back-to-back acked reads (s_dat_i 0x11,0x22,0x33,0x44) while m0 requests -> gnt_o stays 10 for all 4 and m1_dat_o matches each. m0 is granted only after m1 cyc drops.
- Watchdog with timeout=8: m0 strobes and the slave never acks -> exactly 8 cycles after stb, m0_err_o and timeout_o pulse for 1 cycle with s_cyc_o=0 in that cycle. The arbiter then returns to GNT0 or IDLE per m0 cyc.
- Reset mid-op: rst=0 during m1's second beat -> next cycle gnt_o=00, s_cyc_o=0, no ack. Then m0 and m1 request together -> m0 wins.
- Error passthrough: slave asserts s_err_i with s_ack_i=0 -> granted master sees err_o=1 the same cycle, the watchdog counter is 0 the next cycle, and timeout_o stays 0.
